bnn_param_loader: RTL and testbench

Upstream parameter-loading stage for the binary neuron layer. Accepts parameter bytes from the host over a valid/ready handshake and serialises them MSB-first onto the neuron daisy-chain (`setup`/`param_in`), one bit per clock, until every neuron's weights and bias are filled. While shifting, it captures the bits falling out of the chain's tail (`param_out` of the last neuron) and returns them as readback bytes, so the host can read the old parameter image during the load.

---
 rtl/bnn_param_loader.sv | 116 +++++++++++
 tb/tb_bnn_param_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bnn_param_loader.sv
// Serialises host parameter bytes MSB-first onto the binary-neuron daisy chain,
// returning the bits that fall out of the chain tail as readback bytes.
module bnn_param_loader #(
  parameter int NEURONS         = 4,
  parameter int BITS_PER_NEURON = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       chain_out,
  output logic       setup,
  output logic       param_in,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done
);

  localparam int TOTAL_BITS  = NEURONS * BITS_PER_NEURON;
  localparam int TOTAL_BYTES = (TOTAL_BITS + 7) / 8;
  localparam int PAD_BITS    = TOTAL_BYTES * 8 - TOTAL_BITS;
  localparam int CNT_W       = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] TOTAL_BITS_C = CNT_W'(TOTAL_BITS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] totalCnt_q, totalCnt_d;
  logic [3:0]       byteBits_q, byteBits_d;
  logic [7:0]       txSreg_q, txSreg_d;
  logic [7:0]       rxSreg_q, rxSreg_d;
  logic [7:0]       rdData_q, rdData_d;
  logic             rdValid_q, rdValid_d;

  logic [CNT_W-1:0] remaining;
  logic [7:0]       rxShifted;
  logic             lastOfLoad;

  assign remaining  = TOTAL_BITS_C - totalCnt_q;
  assign rxShifted  = {rxSreg_q[6:0], chain_out};
  assign lastOfLoad = (totalCnt_q + CNT_W'(1)) == TOTAL_BITS_C;

  always_comb begin
    state_d    = state_q;
    totalCnt_d = totalCnt_q;
    byteBits_d = byteBits_q;
    txSreg_d   = txSreg_q;
    rxSreg_d   = rxSreg_q;
    rdData_d   = rdData_q;
    rdValid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d    = S_WAIT;
          totalCnt_d = '0;
        end
      end
      S_WAIT: begin
        if (data_valid) begin
          txSreg_d   = data_in;
          rxSreg_d   = '0;
          byteBits_d = (remaining >= CNT_W'(8)) ? 4'd8 : 4'(remaining);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        txSreg_d   = {txSreg_q[6:0], 1'b0};
        rxSreg_d   = rxShifted;
        totalCnt_d = totalCnt_q + CNT_W'(1);
        byteBits_d = byteBits_q - 4'd1;
        // The final partial byte is captured right-aligned, so left-align it on the way out.
        if (byteBits_q == 4'd1) begin
          rdValid_d = 1'b1;
          rdData_d  = lastOfLoad ? (rxShifted << PAD_BITS) : rxShifted;
          state_d   = lastOfLoad ? S_DONE : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      totalCnt_q <= '0;
      byteBits_q <= '0;
      txSreg_q   <= '0;
      rxSreg_q   <= '0;
      rdData_q   <= '0;
      rdValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      totalCnt_q <= totalCnt_d;
      byteBits_q <= byteBits_d;
      txSreg_q   <= txSreg_d;
      rxSreg_q   <= rxSreg_d;
      rdData_q   <= rdData_d;
      rdValid_q  <= rdValid_d;
    end
  end

  assign data_ready = (state_q == S_WAIT);
  assign setup      = (state_q == S_SHIFT);
  assign param_in   = setup & txSreg_q[7];
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign rd_data    = rdData_q;
  assign rd_valid   = rdValid_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader: table of full loads against a behavioural
// neuron chain, plus reset, restart-ignore and single-neuron corner sequences.
module tb_bnn_param_loader;

  typedef struct {
    logic [47:0] bytes;
    logic [43:0] preload;
    int          stall;
    bit          poke;
    logic [43:0] expImage;
    logic [47:0] expRb;
    logic [7:0]  expW0;
    int          expDone;
    int          expReady;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       load_start1 = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic       data_ready, setup, param_in, rd_valid, busy, done, chain_out;
  logic [7:0] rd_data;
  logic       data_ready1, setup1, param_in1, rd_valid1, busy1, done1, chain_out1;
  logic [7:0] rd_data1;

  logic [43:0] chain = '0;
  logic [10:0] chain1 = '0;
  logic        preloadEn = 1'b0;
  logic [43:0] preloadVal = '0;

  int   vecCount = 0;
  int   missCount = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  bnn_param_loader #(.NEURONS(4), .BITS_PER_NEURON(11)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .chain_out(chain_out),
    .setup(setup), .param_in(param_in), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done)
  );

  bnn_param_loader #(.NEURONS(1), .BITS_PER_NEURON(11)) dut1 (
    .clk(clk), .reset(reset), .load_start(load_start1), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready1), .chain_out(chain_out1),
    .setup(setup1), .param_in(param_in1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .busy(busy1), .done(done1)
  );

  // Neuron chain model: the first bit shifted travels all the way to the tail.
  assign chain_out  = chain[43];
  assign chain_out1 = chain1[10];

  always @(posedge clk) begin
    if (preloadEn) chain <= preloadVal;
    else if (setup) chain <= {chain[42:0], param_in};
    if (setup1) chain1 <= {chain1[9:0], param_in1};
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    int cyc, setups, readies, rds, doneCyc, stallLeft, byteIdx;
    logic [43:0] bits;
    logic [47:0] rb;
    v = vecs[idx];
    preloadVal = v.preload;
    preloadEn = 1'b1;
    @(posedge clk); #1;
    preloadEn = 1'b0;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    checkOutput("readyAfterStart", 64'(data_ready), 64'd1);
    cyc = 1; setups = 0; readies = 0; rds = 0; doneCyc = 0;
    stallLeft = v.stall; byteIdx = 0; bits = '0; rb = '0;
    while (cyc <= 200 && doneCyc == 0) begin
      if (setup) begin
        setups++;
        bits = {bits[42:0], param_in};
      end
      if (data_ready) readies++;
      if (rd_valid) begin
        if (rds < 6) rb[47-8*rds -: 8] = rd_data;
        rds++;
      end
      load_start = v.poke && (setup || done);
      if (done) begin
        doneCyc = cyc;
      end else if (data_ready && byteIdx < 6) begin
        if (stallLeft > 0) begin
          data_valid = 1'b0;
          stallLeft--;
        end else begin
          data_valid = 1'b1;
          data_in = v.bytes[47-8*byteIdx -: 8];
          byteIdx++;
          stallLeft = v.stall;
        end
      end else begin
        data_valid = (v.stall == 0);
        data_in = 8'hEE;
      end
      @(posedge clk); #1;
      cyc++;
    end
    load_start = 1'b0;
    data_valid = 1'b0;
    checkOutput("doneCycle", 64'(doneCyc), 64'(v.expDone));
    checkOutput("busyAfterDone", 64'(busy), 64'd0);
    checkOutput("donePulseWidth", 64'(done), 64'd0);
    checkOutput("setupCycles", 64'(setups), 64'd44);
    checkOutput("readyCycles", 64'(readies), 64'(v.expReady));
    checkOutput("paramBits", 64'(bits), 64'(v.expImage));
    checkOutput("chainImage", 64'(chain), 64'(v.expImage));
    checkOutput("neuron0Weights", 64'(chain[7:0]), 64'(v.expW0));
    checkOutput("rdStrobes", 64'(rds), 64'd6);
    checkOutput("readback", 64'(rb), 64'(v.expRb));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("noRestartReady", 64'(data_ready), 64'd0);
    checkOutput("noRestartBusy", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt, acc, s1, r1, d1;
    vecs[0] = '{48'hA53CFF0081F0, 44'h0,           0, 1'b0, 44'hA53CFF0081F, 48'h000000000000, 8'h1F, 51, 6};
    vecs[1] = '{48'h000000000000, 44'h123456789AB, 0, 1'b1, 44'h0,           48'h123456789AB0, 8'h00, 51, 6};
    vecs[2] = '{48'h5AC300FF7E0F, 44'hA53CFF0081F, 3, 1'b0, 44'h5AC300FF7E0, 48'hA53CFF0081F0, 8'hE0, 69, 24};
    vecs[3] = '{48'h8001C003E00F, 44'hFFFFFFFFFFF, 1, 1'b1, 44'h8001C003E00, 48'hFFFFFFFFFFF0, 8'h00, 57, 12};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstSetup", 64'(setup), 64'd0);
    checkOutput("rstParamIn", 64'(param_in), 64'd0);
    checkOutput("rstReady", 64'(data_ready), 64'd0);
    checkOutput("rstRdValid", 64'(rd_valid), 64'd0);
    checkOutput("rstRdData", 64'(rd_data), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    reset = 1'b0;

    // Abort a load with reset in the middle of the third byte.
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    data_valid = 1'b1;
    data_in = 8'hA5;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 20; i++) begin
      if (setup) cnt++;
      if (cnt < 20) begin
        @(posedge clk); #1;
      end
    end
    checkOutput("bitsBeforeReset", 64'(cnt), 64'd20);
    checkOutput("setupBeforeReset", 64'(setup), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncSetup", 64'(setup), 64'd0);
    checkOutput("asyncBusy", 64'(busy), 64'd0);
    checkOutput("asyncReady", 64'(data_ready), 64'd0);
    data_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 4; i++) applyStimulus(i);

    // Single-neuron instance: 8 + 3 bits from two bytes.
    data_valid = 1'b1;
    data_in = 8'hA5;
    load_start1 = 1'b1;
    @(posedge clk); #1;
    load_start1 = 1'b0;
    acc = 0; s1 = 0; r1 = 0; d1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (setup1) s1++;
      if (rd_valid1) r1++;
      if (done1) d1++;
      if (data_ready1) begin
        data_in = (acc == 0) ? 8'hA5 : 8'h3C;
        acc++;
      end else begin
        data_in = 8'hEE;
      end
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    checkOutput("n1Accepts", 64'(acc), 64'd2);
    checkOutput("n1Setups", 64'(s1), 64'd11);
    checkOutput("n1RdStrobes", 64'(r1), 64'd2);
    checkOutput("n1Done", 64'(d1), 64'd1);
    checkOutput("n1Chain", 64'(chain1), 64'h529);
    checkOutput("n1Busy", 64'(busy1), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
